tp_register_file_sb: RTL and testbench
======================================

TP_REGISTER_FILE_SB -- requirements
Module: tp_register_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, data width of each register and port.
REQ-002 Parameter ADDR_W, default 5, register address width; depth DEPTH = 2^ADDR_W.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never written or reserved.
REQ-004 Port Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port Clr_n  in  1  asynchronous, active-low reset.
REQ-006 Port PW  in  DATA_W  write data.
REQ-007 Port RW  in  ADDR_W  write address.
REQ-008 Port LE  in  1  write enable.
REQ-009 Port RA, RB  in  ADDR_W each  read addresses, ports A and B.
REQ-010 Port PA, PB  out  DATA_W each  read data, ports A and B.
REQ-011 Port RSV  in  1  reserve strobe; marks register RV as pending a future write.
REQ-012 Port RV  in  ADDR_W  reserve address.
REQ-013 Port BusyA, BusyB  out  1 each  busy bit of register RA / RB.
REQ-014 Port PendCnt  out  ADDR_W+1  number of registers currently busy.

Function
REQ-015 Storage SHALL be DEPTH registers of DATA_W bits plus one busy bit per register.
REQ-016 Reads SHALL be combinational: PA = reg[RA], PB = reg[RB], BusyA = busy[RA], BusyB = busy[RB], zero cycles of latency.
REQ-017 With ZERO_REG=1, address 0 SHALL read PA/PB = 0 and BusyA/BusyB = 0, regardless of writes or reserves to address 0.
REQ-018 LE=1 at a rising edge SHALL load PW into reg[RW]; the value is visible on PA/PB from the following cycle (except per REQ-030).
REQ-019 LE=1 to a busy register SHALL clear its busy bit at the same edge.
REQ-020 LE=1 to a non-busy register SHALL write data and leave busy at 0.
REQ-021 RSV=1 SHALL set busy[RV] at the rising edge; RSV to an already-busy register keeps it busy and leaves PendCnt unchanged.
REQ-022 RSV=1 and LE=1 with RV==RW in the same cycle: data SHALL be written, and busy[RV] SHALL end at 1 (the reservation wins; a new producer is pending).
REQ-023 RSV=1 and LE=1 with different addresses SHALL both take effect independently at the same edge.
REQ-024 PendCnt SHALL always equal the popcount of the busy bits, updated registered: +1 for a reservation setting a 0 bit, -1 for a write clearing a 1 bit, net 0 when both occur at the same edge; the range is 0..DEPTH-ZERO_REG with no wrap.
REQ-025 With ZERO_REG=1, LE or RSV to address 0 SHALL have no effect on state or PendCnt.

Reset
REQ-026 Clr_n=0 SHALL immediately, without waiting for a clock edge, clear all registers to 0, all busy bits to 0 and PendCnt to 0; PA, PB, BusyA and BusyB therefore read 0.
REQ-027 Clr_n deasserted SHALL resume normal operation at the first rising edge after release.
REQ-028 Writes or reserves presented during reset SHALL be discarded.

Configuration
REQ-029 Macro TP_RF_BYPASS_EN selects write-to-read forwarding.
REQ-030 With TP_RF_BYPASS_EN defined: when LE=1 and RW==RA (or RW==RB) in the same cycle, and the address is not zero when ZERO_REG=1:
  - PA (or PB) SHALL equal PW combinationally.
  - BusyA (or BusyB) SHALL read 0, unless RSV=1 with RV==RW.
REQ-031 Without TP_RF_BYPASS_EN, reads SHALL return only stored state (REQ-016), with no forwarding.

Verification
REQ-032 After reset: write R5=0xDEADBEEF, then the next cycle set RA=5, RB=0 -> PA=0xDEADBEEF, PB=0.
REQ-033 RSV with RV=7 -> BusyA=1 for RA=7 and PendCnt=1; then LE with RW=7, PW=0x12 -> BusyA=0, PendCnt=0, PA=0x12.
REQ-034 Same cycle RSV, RV=9 and LE, RW=9, PW=0x55 -> next cycle PA=0x55, BusyA=1, PendCnt=1; a second RSV with RV=9 -> PendCnt stays 1.
REQ-035 RSV, RV=3 and LE to busy R4 at the same edge -> busy[3]=1, busy[4]=0, PendCnt unchanged.
REQ-036 Reserve R1..R31 -> PendCnt=31; RSV/LE to R0 -> no change; assert Clr_n=0 mid-clock -> all outputs 0 before the next edge.
REQ-037 With TP_RF_BYPASS_EN: LE with RW=RA=12, PW=0xA5A5A5A5 -> PA=0xA5A5A5A5 in the same cycle; without the macro, PA holds the old value until the next cycle.

Source files
------------

// File: rtl/tp_register_file_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard and pending counter.
// Define TP_RF_BYPASS_EN to forward same-cycle write data and busy state onto the read ports.
module tp_register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic [DATA_W-1:0] PW,
  input  logic [ADDR_W-1:0] RW,
  input  logic              LE,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  input  logic              RSV,
  input  logic [ADDR_W-1:0] RV,
  output logic              BusyA,
  output logic              BusyB,
  output logic [ADDR_W:0]   PendCnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPORT = 2;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              pend_cnt_q, pend_cnt_d;
  logic                         le_ok, rsv_ok, cnt_inc, cnt_dec;

  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;
  logic [NPORT-1:0]             rd_busy;

  // Register 0 is hardwired when ZERO_REG is set, so its strobes are dropped here.
  assign le_ok  = LE  && !((ZERO_REG != 0) && (RW == '0));
  assign rsv_ok = RSV && !((ZERO_REG != 0) && (RV == '0));

  // A reserve to the register being written keeps it busy: the new producer is still pending.
  assign cnt_inc = rsv_ok && !busy_q[RV];
  assign cnt_dec = le_ok && busy_q[RW] && !(rsv_ok && (RV == RW));

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    if (le_ok) begin
      regs_d[RW] = PW;
      busy_d[RW] = 1'b0;
    end
    if (rsv_ok) busy_d[RV] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      regs_q     <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign rd_addr = {RB, RA};

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NPORT; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
`ifdef TP_RF_BYPASS_EN
      if (le_ok && (RW == rd_addr[p])) begin
        rd_data[p] = PW;
        rd_busy[p] = rsv_ok && (RV == RW);
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign PA      = rd_data[0];
  assign PB      = rd_data[1];
  assign BusyA   = rd_busy[0];
  assign BusyB   = rd_busy[1];
  assign PendCnt = pend_cnt_q;
endmodule

// File: tb/tb_tp_register_file_sb.sv
// Directed bench for tp_register_file_sb; expected values are hand-derived constants.
module tb_tp_register_file_sb;
`ifdef TP_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Clr_n;
  logic [31:0] PW, PA, PB;
  logic [4:0]  RW, RA, RB, RV;
  logic        LE, RSV, BusyA, BusyB;
  logic [5:0]  PendCnt;

  int n_total = 0;
  int n_bad   = 0;

  tp_register_file_sb dut (
    .Clk(Clk), .Clr_n(Clr_n), .PW(PW), .RW(RW), .LE(LE), .RA(RA), .RB(RB),
    .PA(PA), .PB(PB), .RSV(RSV), .RV(RV), .BusyA(BusyA), .BusyB(BusyB),
    .PendCnt(PendCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    LE  = 1'b0;
    RSV = 1'b0;
  endtask

  initial begin
    Clr_n = 1'b0; PW = '0; RW = '0; LE = 1'b0; RSV = 1'b0; RV = '0;
    RA = 5'd5; RB = 5'd9;
    #3;
    chk("rst_pa", PA, 0);
    chk("rst_pb", PB, 0);
    chk("rst_busya", {31'd0, BusyA}, 0);
    chk("rst_busyb", {31'd0, BusyB}, 0);
    chk("rst_pend", {26'd0, PendCnt}, 0);

    // strobes during reset must be discarded
    LE = 1'b1; RW = 5'd5; PW = 32'h1; RSV = 1'b1; RV = 5'd9;
    tick; tick;
    Clr_n = 1'b1; idle;
    #1;
    chk("rst_discard_pa", PA, 0);
    chk("rst_discard_pend", {26'd0, PendCnt}, 0);

    // write R5, read next cycle
    RA = 5'd1; RB = 5'd1;
    LE = 1'b1; RW = 5'd5; PW = 32'hDEADBEEF;
    tick; idle;
    RA = 5'd5; RB = 5'd0;
    #1;
    chk("wr_r5_pa", PA, 32'hDEADBEEF);
    chk("wr_r0_pb", PB, 0);

    // reserve R7 then write it
    RSV = 1'b1; RV = 5'd7;
    tick; idle;
    RA = 5'd7;
    #1;
    chk("rsv7_busya", {31'd0, BusyA}, 1);
    chk("rsv7_pend", {26'd0, PendCnt}, 1);
    LE = 1'b1; RW = 5'd7; PW = 32'h12;
    tick; idle;
    #1;
    chk("wr7_busya", {31'd0, BusyA}, 0);
    chk("wr7_pend", {26'd0, PendCnt}, 0);
    chk("wr7_pa", PA, 32'h12);

    // same-cycle reserve and write to R9: reservation wins
    RA = 5'd1;
    RSV = 1'b1; RV = 5'd9; LE = 1'b1; RW = 5'd9; PW = 32'h55;
    tick; idle;
    RA = 5'd9;
    #1;
    chk("rw9_pa", PA, 32'h55);
    chk("rw9_busya", {31'd0, BusyA}, 1);
    chk("rw9_pend", {26'd0, PendCnt}, 1);
    RSV = 1'b1; RV = 5'd9;
    tick; idle;
    #1;
    chk("rsv9_again_pend", {26'd0, PendCnt}, 1);

    // reserve R3 while writing busy R4
    RSV = 1'b1; RV = 5'd4;
    tick; idle;
    #1;
    chk("rsv4_pend", {26'd0, PendCnt}, 2);
    RA = 5'd1; RB = 5'd1;
    RSV = 1'b1; RV = 5'd3; LE = 1'b1; RW = 5'd4; PW = 32'h44;
    tick; idle;
    RA = 5'd3; RB = 5'd4;
    #1;
    chk("mix_busy3", {31'd0, BusyA}, 1);
    chk("mix_busy4", {31'd0, BusyB}, 0);
    chk("mix_pb", PB, 32'h44);
    chk("mix_pend", {26'd0, PendCnt}, 2);

    // forwarding (or not) on a same-cycle write to the read address
    RA = 5'd12; RB = 5'd5;
    LE = 1'b1; RW = 5'd12; PW = 32'hA5A5A5A5;
    #1;
    chk("byp_pa", PA, BYP ? 32'hA5A5A5A5 : 32'h0);
    chk("byp_busya", {31'd0, BusyA}, 0);
    chk("byp_pb", PB, 32'hDEADBEEF);
    tick; idle;
    #1;
    chk("byp_after_pa", PA, 32'hA5A5A5A5);
    RSV = 1'b1; RV = 5'd12; LE = 1'b1; RW = 5'd12; PW = 32'h1;
    #1;
    chk("byp_rsv_pa", PA, BYP ? 32'h1 : 32'hA5A5A5A5);
    chk("byp_rsv_busya", {31'd0, BusyA}, BYP ? 1 : 0);
    tick; idle;
    #1;
    chk("rsv12_busya", {31'd0, BusyA}, 1);
    chk("rsv12_pend", {26'd0, PendCnt}, 3);
    LE = 1'b1; RW = 5'd12; PW = 32'h2;
    #1;
    chk("byp_clr_busya", {31'd0, BusyA}, BYP ? 0 : 1);
    tick; idle;
    #1;
    chk("wr12_pa", PA, 32'h2);
    chk("wr12_busya", {31'd0, BusyA}, 0);
    chk("wr12_pend", {26'd0, PendCnt}, 2);

    // fill every reservable register
    for (int i = 1; i < 32; i++) begin
      RSV = 1'b1; RV = 5'(i);
      tick;
    end
    idle;
    #1;
    chk("full_pend", {26'd0, PendCnt}, 31);

    // register 0 ignores write and reserve, including forwarding
    RA = 5'd0; RB = 5'd31;
    LE = 1'b1; RW = 5'd0; PW = 32'hFFFFFFFF; RSV = 1'b1; RV = 5'd0;
    #1;
    chk("r0_same_pa", PA, 0);
    chk("r0_same_busya", {31'd0, BusyA}, 0);
    tick; idle;
    #1;
    chk("r0_pa", PA, 0);
    chk("r0_busya", {31'd0, BusyA}, 0);
    chk("r0_pend", {26'd0, PendCnt}, 31);
    chk("r31_busyb", {31'd0, BusyB}, 1);

    // asynchronous clear mid-cycle
    RA = 5'd5; RB = 5'd31;
    #1;
    chk("pre_clr_pa", PA, 32'hDEADBEEF);
    Clr_n = 1'b0;
    #1;
    chk("clr_pa", PA, 0);
    chk("clr_busyb", {31'd0, BusyB}, 0);
    chk("clr_pend", {26'd0, PendCnt}, 0);
    RA = 5'd9;
    #1;
    chk("clr_busya", {31'd0, BusyA}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
